mic_i2s_ctrl: RTL

- Master-mode sequencer for an I2S MEMS microphone. Generates the bit clock `mclk` and word-select `ws` from the system clock.
- Deserializes the selected channel slot(s) into parallel samples and hands each sample downstream over a valid/ready interface, normally to the audio FIFO.
- Replaces ad-hoc free-running capture. Capture runs only when enabled, starts and stops only on frame boundaries, and reports overflow.

---
 rtl/mic_pkg.sv | 26 ++
 rtl/mic_sck_gen.sv | 37 +++
 rtl/mic_i2s_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mic_pkg.sv
// Shared types and defaults for the I2S MEMS microphone capture controller.
package mic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    CAPTURE = 2'd2,
    STOP    = 2'd3
  } mic_state_t;

  localparam int         DEF_CLK_DIV        = 2;
  localparam int         DEF_SLOT_BITS      = 32;
  localparam int         DEF_SAMPLE_BITS    = 18;
  localparam logic [1:0] DEF_CHAN_MASK      = 2'b01;
  localparam int         DEF_DISCARD_FRAMES = 2;

  // Channel mask bits: left slot is ws=0, right slot is ws=1.
  localparam logic [1:0] CHAN_LEFT  = 2'b01;
  localparam logic [1:0] CHAN_RIGHT = 2'b10;

  // True when the slot selected by ws is enabled in the mask.
  function automatic logic chan_on(input logic [1:0] mask, input logic right);
    return |(mask & (right ? CHAN_RIGHT : CHAN_LEFT));
  endfunction

endpackage

// File: rtl/mic_sck_gen.sv
// Bit-clock generator: mclk toggles every CLK_DIV clk while run is high.
// The ticks flag the clk cycle at whose closing edge mclk rises or falls.
module mic_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic mclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc        = run && (cnt == '0);
  assign rise_tick = tc && !mclk;
  assign fall_tick = tc && mclk;

  // Half-period down-counter; idles parked at reload with mclk low.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt  <= RELOAD;
      mclk <= 1'b0;
    end else if (tc) begin
      cnt  <= RELOAD;
      mclk <= ~mclk;
    end else begin
      cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/mic_i2s_ctrl.sv
// Master-mode I2S microphone sequencer: drives mclk/ws, deserializes the
// enabled slots and presents samples on a valid/ready port with sticky
// overflow reporting. Capture starts and stops on frame boundaries.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | clocks parked (mclk=0, ws=0), counters cleared, wait for en
//   DISCARD | frames clocked for mic start-up, completions suppressed
//   CAPTURE | normal capture of slots enabled in CHAN_MASK
//   STOP    | en dropped; finish the current frame, then return to IDLE
module mic_i2s_ctrl
  import mic_pkg::*;
#(
  parameter int         CLK_DIV        = DEF_CLK_DIV,
  parameter int         SLOT_BITS      = DEF_SLOT_BITS,
  parameter int         SAMPLE_BITS    = DEF_SAMPLE_BITS,
  parameter logic [1:0] CHAN_MASK      = DEF_CHAN_MASK,
  parameter int         DISCARD_FRAMES = DEF_DISCARD_FRAMES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  output logic                   mclk,
  output logic                   ws,
  input  logic                   dataint,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_right,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic                   busy
);

  localparam int BW = $clog2(SLOT_BITS);
  localparam int FW = $clog2(DISCARD_FRAMES + 2);

  mic_state_t             state, next_state;
  logic                   run;
  logic                   rise_tick, fall_tick;
  logic                   frame_end;
  logic                   sample_bit;
  logic                   capture_ok;
  logic                   complete;
  logic                   drop;
  logic [BW-1:0]          bit_idx;
  logic [FW-1:0]          frames_left;
  logic [SAMPLE_BITS-1:0] shift_q, shift_next;

  assign run  = (state != IDLE);
  assign busy = run;

  mic_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mclk      (mclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Frame ends on the falling edge that closes the right slot.
  assign frame_end  = fall_tick && (bit_idx == BW'(SLOT_BITS - 1)) && ws;
  // b=0 is the I2S one-bit delay; only b=1..SAMPLE_BITS carry data.
  assign sample_bit = rise_tick && (bit_idx != '0) && (bit_idx <= BW'(SAMPLE_BITS));
  assign shift_next = {shift_q[SAMPLE_BITS-2:0], dataint};
  // A stop requested during start-up must not emit samples either.
  assign capture_ok = (state == CAPTURE) || ((state == STOP) && (frames_left == '0));
  assign complete   = capture_ok && rise_tick && (bit_idx == BW'(SAMPLE_BITS))
                      && chan_on(CHAN_MASK, ws);
  assign drop       = complete && sample_valid && !sample_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; en low at a frame end leaves directly for IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:
        if (en) next_state = (DISCARD_FRAMES == 0) ? CAPTURE : DISCARD;
      DISCARD:
        if (!en)                                        next_state = frame_end ? IDLE : STOP;
        else if (frame_end && (frames_left == FW'(1))) next_state = CAPTURE;
      CAPTURE:
        if (!en) next_state = frame_end ? IDLE : STOP;
      STOP:
        if (frame_end) next_state = IDLE;
      default:
        next_state = IDLE;
    endcase
  end

  // Start-up frames still to be thrown away in this run.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE))
      frames_left <= FW'(DISCARD_FRAMES);
    else if ((state == DISCARD) && frame_end && (frames_left != '0))
      frames_left <= frames_left - FW'(1);
  end

  // Bit index within the slot and word select, advanced on mclk falls.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE)) begin
      bit_idx <= '0;
      ws      <= 1'b0;
    end else if (fall_tick) begin
      if (bit_idx == BW'(SLOT_BITS - 1)) begin
        bit_idx <= '0;
        ws      <= ~ws;
      end else begin
        bit_idx <= bit_idx + BW'(1);
      end
    end
  end

  // Serial-in shift register, MSB first.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE)) shift_q <= '0;
    else if (sample_bit)          shift_q <= shift_next;
  end

  // Output holding register, handshake and sticky overflow; a pending
  // sample is deliberately kept across the return to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_data  <= '0;
      sample_right <= 1'b0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (complete && !drop) begin
        sample_data  <= shift_next;
        sample_right <= ws;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
